// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Bits needed to count 0..n-1 (minimum 1).
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output V.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] O,
  output logic         Borrow,
  output logic         busy,
  output logic         done
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic         V
`endif
);

  localparam int unsigned CW = clog2(N);

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [N-1:0]    o_q;
  logic            borrow_q;
  logic            busy_q;
  logic            done_q;
  logic            d;
  logic            bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic            v_q;
`endif

  full_sub u_full_sub (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (d),
    .bout (bout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      o_q      <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      v_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            cnt_q    <= '0;
            o_q      <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= StShift;
`ifdef SERIAL_SUB_OVERFLOW_EN
            v_q      <= 1'b0;
`endif
          end else begin
            state_q <= StIdle;
          end
        end
        StShift: begin
          // Difference bits enter at the MSB so the LSB lands at bit 0 after N shifts.
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          o_q      <= {d, o_q[N-1:1]};
          borrow_q <= bout;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
`ifdef SERIAL_SUB_OVERFLOW_EN
            v_q     <= borrow_q ^ bout;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign O      = o_q;
  assign Borrow = borrow_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign V      = v_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub against an arithmetic reference model.
module tb_serial_sub;

  localparam int unsigned N = 5;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] O;
  logic         Borrow;
  logic         busy;
  logic         done;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         V;
`endif

  int tests;
  int failed;

  serial_sub #(.N(N)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A      (A),
    .B      (B),
    .O      (O),
    .Borrow (Borrow),
    .busy   (busy),
    .done   (done)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .V      (V)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular arithmetic on the operands.
  function automatic logic [N-1:0] exp_o(input logic [N-1:0] a, input logic [N-1:0] b);
    int unsigned diff;
    diff = (int'(a) - int'(b) + (1 << N)) % (1 << N);
    return N'(diff);
  endfunction

  function automatic logic exp_borrow(input logic [N-1:0] a, input logic [N-1:0] b);
    return int'(a) < int'(b);
  endfunction

  function automatic logic exp_v(input logic [N-1:0] a, input logic [N-1:0] b);
    int sa;
    int sb;
    int sd;
    sa = a[N-1] ? int'(a) - (1 << N) : int'(a);
    sb = b[N-1] ? int'(b) - (1 << N) : int'(b);
    sd = sa - sb;
    return (sd > (1 << (N - 1)) - 1) || (sd < -(1 << (N - 1)));
  endfunction

  task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
    check({tag, "_done"}, 32'(done), 32'(1));
    check({tag, "_busy_off"}, 32'(busy), 32'(0));
    check({tag, "_O"}, 32'(O), 32'(exp_o(a, b)));
    check({tag, "_Borrow"}, 32'(Borrow), 32'(exp_borrow(a, b)));
`ifdef SERIAL_SUB_OVERFLOW_EN
    check({tag, "_V"}, 32'(V), 32'(exp_v(a, b)));
`endif
  endtask

  // One operation: start in cycle 0, done expected in cycle N+1, then IDLE hold.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit poke);
    A = a;
    B = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= int'(N); c++) begin
      A = N'($urandom);
      B = N'($urandom);
      start = poke && (c == 3);
      check({tag, "_busy"}, 32'(busy), 32'(1));
      check({tag, "_no_done"}, 32'(done), 32'(0));
      tick();
    end
    start = 1'b0;
    check_result(tag, a, b);
    tick();
    check({tag, "_pulse_end"}, 32'(done), 32'(0));
    check({tag, "_idle"}, 32'(busy), 32'(0));
    check({tag, "_hold_O"}, 32'(O), 32'(exp_o(a, b)));
    check({tag, "_hold_Borrow"}, 32'(Borrow), 32'(exp_borrow(a, b)));
  endtask

  initial begin
    logic [N-1:0] qa [4];
    logic [N-1:0] qb [4];
    tests  = 0;
    failed = 0;
    rst    = 1'b1;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    tick();
    tick();
    check("rst_O", 32'(O), 32'(0));
    check("rst_Borrow", 32'(Borrow), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));

    // Reset wins over start in the same cycle.
    start = 1'b1;
    A = 5'b01010;
    B = 5'b00011;
    tick();
    check("rst_prio_busy", 32'(busy), 32'(0));
    rst = 1'b0;
    start = 1'b0;
    tick();
    check("rst_prio_idle", 32'(busy), 32'(0));

    run_op("all_ones", 5'b11111, 5'b11111, 1'b0);
    run_op("wrap", 5'b00000, 5'b00001, 1'b0);
    run_op("mid", 5'b01010, 5'b00011, 1'b0);
    run_op("ovf", 5'b10000, 5'b00001, 1'b0);
    run_op("poke", 5'b00110, 5'b10101, 1'b1);

    // Reset in cycle 3 abandons the operation.
    A = 5'b10101;
    B = 5'b00111;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_O", 32'(O), 32'(0));
    check("midrst_Borrow", 32'(Borrow), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    for (int c = 0; c < int'(N) + 2; c++) begin
      check("midrst_no_done", 32'(done), 32'(0));
      tick();
    end
    run_op("after_rst", 5'b10101, 5'b00111, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op("rand", N'($urandom), N'($urandom), i[0]);
    end

    // start held high: results every N+1 cycles.
    for (int i = 0; i < 4; i++) begin
      qa[i] = N'($urandom);
      qb[i] = N'($urandom);
    end
    A = qa[0];
    B = qb[0];
    start = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      for (int c = 1; c <= int'(N); c++) begin
        A = N'($urandom);
        B = N'($urandom);
        check("b2b_busy", 32'(busy), 32'(1));
        check("b2b_no_done", 32'(done), 32'(0));
        tick();
      end
      check_result("b2b", qa[i], qb[i]);
      if (i < 3) begin
        A = qa[i + 1];
        B = qb[i + 1];
      end else begin
        start = 1'b0;
      end
      tick();
    end
    check("b2b_end_done", 32'(done), 32'(0));
    check("b2b_end_busy", 32'(busy), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
